// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single-ported unified memory between instruction fetch and the
// load/store unit. Only one transaction is outstanding at a time. The LSU has
// fixed priority. After STARVE_MAX consecutive LSU wins over a waiting fetch,
// the next contested decision goes to fetch instead.
//
// Ports
//   i_clk, i_rst_n    clock, synchronous active-low reset
//   i_if_* / o_if_*   fetch request/address/kill, grant, response pulse + data, stall
//   i_ls_* / o_ls_*   LSU request/payload, grant, response pulse + data, stall
//   o_mem_*           registered memory request and payload, stable while o_mem_req
//   i_mem_*           memory completion (ack) and read data
//
// state | meaning
// IDLE  | nothing outstanding; grants are decided combinationally here
// FETCH | fetch transaction outstanding on the memory port
// DATA  | LSU transaction outstanding on the memory port
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  input  logic        i_if_kill,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  output logic        o_if_stall,
  input  logic        i_ls_req,
  input  logic        i_ls_we,
  input  logic [31:0] i_ls_addr,
  input  logic [31:0] i_ls_wdata,
  input  logic [3:0]  i_ls_bmask,
  output logic        o_ls_gnt,
  output logic        o_ls_rvalid,
  output logic [31:0] o_ls_rdata,
  output logic        o_ls_stall,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_bmask,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2
  } state_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic        kill_q, kill_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_bmask_q, mem_bmask_d;
  logic        if_rvalid_q, if_rvalid_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        ls_rvalid_q, ls_rvalid_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;

  logic if_elig, ls_elig, if_gnt, ls_gnt, kill_seen;

  // A requester in its own rvalid cycle still holds req, but that request is
  // already served, so it must not win again.
  always_comb begin
    if_elig = i_if_req & ~i_if_kill & ~if_rvalid_q;
    ls_elig = i_ls_req & ~ls_rvalid_q;
    if_gnt  = 1'b0;
    ls_gnt  = 1'b0;
    // Grants are suppressed under reset because the grant edge would not take effect.
    if (state_q == ST_IDLE && i_rst_n) begin
      if (if_elig && (!ls_elig || starve_q == STARVE_LIM)) begin
        if_gnt = 1'b1;
      end else if (ls_elig) begin
        ls_gnt = 1'b1;
      end
    end
  end

  // A kill in the ack cycle itself must also discard the result.
  assign kill_seen = kill_q | i_if_kill;

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    kill_d      = kill_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_bmask_d = mem_bmask_q;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rvalid_d = 1'b0;
    ls_rdata_d  = ls_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (if_gnt) begin
          state_d     = ST_FETCH;
          mem_we_d    = 1'b0;
          mem_addr_d  = i_if_addr;
          mem_wdata_d = '0;
          mem_bmask_d = 4'b0000;
          starve_d    = '0;
        end else if (ls_gnt) begin
          state_d     = ST_DATA;
          mem_we_d    = i_ls_we;
          mem_addr_d  = i_ls_addr;
          mem_wdata_d = i_ls_wdata;
          mem_bmask_d = i_ls_bmask;
          if (!if_elig) begin
            starve_d = '0;
          end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + 4'd1;
          end
        end
      end
      ST_FETCH: begin
        kill_d = kill_seen;
        if (i_mem_ack) begin
          state_d = ST_IDLE;
          kill_d  = 1'b0;
          if (!kill_seen) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = i_mem_rdata;
          end
        end
      end
      ST_DATA: begin
        if (i_mem_ack) begin
          state_d     = ST_IDLE;
          ls_rvalid_d = 1'b1;
          ls_rdata_d  = mem_we_q ? 32'd0 : i_mem_rdata;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      starve_q    <= '0;
      kill_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_bmask_q <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rvalid_q <= 1'b0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      kill_q      <= kill_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_bmask_q <= mem_bmask_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rvalid_q <= ls_rvalid_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign o_if_gnt    = if_gnt;
  assign o_ls_gnt    = ls_gnt;
  assign o_if_rvalid = if_rvalid_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_ls_rvalid = ls_rvalid_q;
  assign o_ls_rdata  = ls_rdata_q;
  assign o_if_stall  = i_if_req & ~if_rvalid_q & ~i_if_kill;
  assign o_ls_stall  = i_ls_req & ~ls_rvalid_q;
  assign o_mem_req   = (state_q != ST_IDLE);
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_bmask = mem_bmask_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_if_req, i_if_kill;
  logic [31:0] i_if_addr;
  logic        o_if_gnt, o_if_rvalid, o_if_stall;
  logic [31:0] o_if_rdata;
  logic        i_ls_req, i_ls_we;
  logic [31:0] i_ls_addr, i_ls_wdata;
  logic [3:0]  i_ls_bmask;
  logic        o_ls_gnt, o_ls_rvalid, o_ls_stall;
  logic [31:0] o_ls_rdata;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_bmask;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;

  mem_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .i_if_kill(i_if_kill),
    .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .o_if_stall(o_if_stall),
    .i_ls_req(i_ls_req), .i_ls_we(i_ls_we), .i_ls_addr(i_ls_addr),
    .i_ls_wdata(i_ls_wdata), .i_ls_bmask(i_ls_bmask),
    .o_ls_gnt(o_ls_gnt), .o_ls_rvalid(o_ls_rvalid), .o_ls_rdata(o_ls_rdata),
    .o_ls_stall(o_ls_stall),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;

  task automatic check1(input string tag, input logic obs, input logic expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, expv);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
    end
  endtask

  // inputs change 1 time unit after the rising edge, outputs are sampled 2 later
  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    i_if_req = 1'b0; i_if_addr = '0; i_if_kill = 1'b0;
    i_ls_req = 1'b0; i_ls_we = 1'b0; i_ls_addr = '0; i_ls_wdata = '0; i_ls_bmask = '0;
    i_mem_ack = 1'b0; i_mem_rdata = '0;
  endtask

  // Transaction-level reference: requesters, memory responder and the
  // arbitration/starvation rule expressed directly as grant bookkeeping.
  bit          f_act, l_act, f_rv, l_rv, f_rv_n, l_rv_n;
  logic [31:0] f_addr, l_addr, l_wdata, f_exp, l_exp;
  bit          l_we;
  logic [3:0]  l_bm;
  bit          busy, owner_ls, killed;
  bit          p_we;
  logic [31:0] p_addr, p_wdata;
  logic [3:0]  p_bm;
  int          starve, mem_wait;
  int          gq[$];

  // mode 1: both sides always request, 1-cycle memory, fetch redirected
  // (killed) in every LSU response cycle so the starvation guard is exercised.
  task automatic model_cycle(input int mode);
    bit fe, le, fg, lg, ack, kill;
    logic [31:0] rd;
    if (f_rv) f_act = 1'b0;
    if (l_rv) l_act = 1'b0;
    f_rv = f_rv_n; l_rv = l_rv_n;
    f_rv_n = 1'b0; l_rv_n = 1'b0;
    if (!f_act && (mode == 1 || $urandom_range(0, 2) == 0)) begin
      f_act = 1'b1;
      f_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (!l_act && (mode == 1 || $urandom_range(0, 3) != 0)) begin
      l_act = 1'b1;
      l_addr = $urandom & 32'hFFFF_FFFC;
      l_we = (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      l_wdata = $urandom;
      l_bm = 4'($urandom_range(0, 15));
    end
    if (mode == 1) kill = l_rv;
    else kill = f_act && !f_rv && ($urandom_range(0, 11) == 0);
    ack = 1'b0;
    if (busy) begin
      if (mem_wait == 0) ack = 1'b1;
      else mem_wait--;
    end
    rd = $urandom;
    i_if_req = f_act; i_if_addr = f_addr; i_if_kill = kill;
    i_ls_req = l_act; i_ls_we = l_we; i_ls_addr = l_addr;
    i_ls_wdata = l_wdata; i_ls_bmask = l_bm;
    i_mem_ack = ack; i_mem_rdata = rd;
    settle();

    fe = f_act && !kill && !f_rv;
    le = l_act && !l_rv;
    fg = 1'b0; lg = 1'b0;
    if (!busy) begin
      if (fe && le) begin
        if (starve == STARVE_MAX) fg = 1'b1;
        else lg = 1'b1;
      end else if (fe) fg = 1'b1;
      else if (le) lg = 1'b1;
    end
    check1("m_if_gnt", o_if_gnt, fg);
    check1("m_ls_gnt", o_ls_gnt, lg);
    check1("m_mem_req", o_mem_req, busy);
    check1("m_if_stall", o_if_stall, f_act && !f_rv && !kill);
    check1("m_ls_stall", o_ls_stall, l_act && !l_rv);
    check1("m_if_rvalid", o_if_rvalid, f_rv);
    check1("m_ls_rvalid", o_ls_rvalid, l_rv);
    if (f_rv) check32("m_if_rdata", o_if_rdata, f_exp);
    if (l_rv) check32("m_ls_rdata", o_ls_rdata, l_exp);
    if (busy) begin
      check32("m_mem_addr", o_mem_addr, p_addr);
      check1("m_mem_we", o_mem_we, p_we);
      check32("m_mem_bmask", 32'(o_mem_bmask), 32'(p_bm));
      if (p_we) check32("m_mem_wdata", o_mem_wdata, p_wdata);
    end
    if (o_if_gnt) gq.push_back(0);
    if (o_ls_gnt) gq.push_back(1);

    if (busy) begin
      if (!owner_ls && kill) killed = 1'b1;
      if (ack) begin
        busy = 1'b0;
        if (owner_ls) begin
          l_rv_n = 1'b1;
          l_exp = l_we ? 32'd0 : rd;
        end else if (!killed) begin
          f_rv_n = 1'b1;
          f_exp = rd;
        end
        killed = 1'b0;
      end
    end
    if (fg || lg) begin
      busy = 1'b1;
      owner_ls = lg;
      mem_wait = (mode == 1) ? 0 : $urandom_range(0, 2);
      p_we = lg ? l_we : 1'b0;
      p_addr = lg ? l_addr : f_addr;
      p_wdata = l_wdata;
      p_bm = lg ? l_bm : 4'b0000;
      if (fg || !fe) starve = 0;
      else if (starve < STARVE_MAX) starve++;
    end
    if (kill) f_addr = $urandom & 32'hFFFF_FFFC;
    cyc();
  endtask

  initial begin
    int  n_ls;
    bit  seen_f;
    clear_inputs();
    i_rst_n = 1'b0;
    cyc(); cyc(); settle();
    check1("rst_if_gnt", o_if_gnt, 1'b0);
    check1("rst_ls_gnt", o_ls_gnt, 1'b0);
    check1("rst_if_rvalid", o_if_rvalid, 1'b0);
    check1("rst_ls_rvalid", o_ls_rvalid, 1'b0);
    check32("rst_if_rdata", o_if_rdata, 32'd0);
    check32("rst_ls_rdata", o_ls_rdata, 32'd0);
    check1("rst_mem_req", o_mem_req, 1'b0);
    check1("rst_mem_we", o_mem_we, 1'b0);
    check32("rst_mem_addr", o_mem_addr, 32'd0);
    check32("rst_mem_wdata", o_mem_wdata, 32'd0);
    check32("rst_mem_bmask", 32'(o_mem_bmask), 32'd0);
    check1("rst_if_stall", o_if_stall, 1'b0);
    check1("rst_ls_stall", o_ls_stall, 1'b0);
    i_rst_n = 1'b1;
    cyc();

    // lone fetch, ack on the first o_mem_req cycle
    i_if_req = 1'b1; i_if_addr = 32'h0000_0010; settle();
    check1("f1_gnt_c0", o_if_gnt, 1'b1);
    check1("f1_stall_c0", o_if_stall, 1'b1);
    check1("f1_memreq_c0", o_mem_req, 1'b0);
    cyc(); i_mem_ack = 1'b1; i_mem_rdata = 32'h0000_0013; settle();
    check1("f1_memreq_c1", o_mem_req, 1'b1);
    check32("f1_addr_c1", o_mem_addr, 32'h0000_0010);
    check1("f1_we_c1", o_mem_we, 1'b0);
    check32("f1_bmask_c1", 32'(o_mem_bmask), 32'd0);
    check1("f1_stall_c1", o_if_stall, 1'b1);
    check1("f1_gnt_c1", o_if_gnt, 1'b0);
    cyc(); i_mem_ack = 1'b0; i_mem_rdata = 32'hFFFF_FFFF; settle();
    check1("f1_rvalid_c2", o_if_rvalid, 1'b1);
    check32("f1_rdata_c2", o_if_rdata, 32'h0000_0013);
    check1("f1_stall_c2", o_if_stall, 1'b0);
    check1("f1_regnt_c2", o_if_gnt, 1'b0);
    check1("f1_memreq_c2", o_mem_req, 1'b0);
    cyc(); i_if_req = 1'b0; settle();
    check1("f1_rvalid_c3", o_if_rvalid, 1'b0);

    // load and fetch together: LSU first, fetch in the LSU rvalid cycle
    cyc();
    i_if_req = 1'b1; i_if_addr = 32'h0000_0014;
    i_ls_req = 1'b1; i_ls_we = 1'b0; i_ls_addr = 32'h0000_0200; settle();
    check1("lf_ls_gnt", o_ls_gnt, 1'b1);
    check1("lf_if_gnt", o_if_gnt, 1'b0);
    cyc(); i_mem_ack = 1'b1; i_mem_rdata = 32'hA5A5_0001; settle();
    check32("lf_ls_addr", o_mem_addr, 32'h0000_0200);
    check1("lf_ls_we", o_mem_we, 1'b0);
    cyc(); i_mem_ack = 1'b0; settle();
    check1("lf_ls_rvalid", o_ls_rvalid, 1'b1);
    check32("lf_ls_rdata", o_ls_rdata, 32'hA5A5_0001);
    check1("lf_ls_stall", o_ls_stall, 1'b0);
    check1("lf_if_gnt2", o_if_gnt, 1'b1);
    check1("lf_ls_regnt", o_ls_gnt, 1'b0);
    cyc(); i_ls_req = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'h0000_0093; settle();
    check32("lf_if_addr", o_mem_addr, 32'h0000_0014);
    cyc(); i_mem_ack = 1'b0; settle();
    check1("lf_if_rvalid", o_if_rvalid, 1'b1);
    check32("lf_if_rdata", o_if_rdata, 32'h0000_0093);
    cyc(); i_if_req = 1'b0;

    // store
    cyc();
    i_ls_req = 1'b1; i_ls_we = 1'b1; i_ls_addr = 32'h0000_0300;
    i_ls_wdata = 32'hDEAD_BEEF; i_ls_bmask = 4'b0011; settle();
    check1("st_gnt", o_ls_gnt, 1'b1);
    cyc(); i_mem_ack = 1'b1; i_mem_rdata = 32'h1234_5678; settle();
    check1("st_memreq", o_mem_req, 1'b1);
    check1("st_we", o_mem_we, 1'b1);
    check32("st_addr", o_mem_addr, 32'h0000_0300);
    check32("st_wdata", o_mem_wdata, 32'hDEAD_BEEF);
    check32("st_bmask", 32'(o_mem_bmask), 32'h0000_0003);
    cyc(); i_mem_ack = 1'b0; settle();
    check1("st_rvalid", o_ls_rvalid, 1'b1);
    check32("st_rdata", o_ls_rdata, 32'd0);
    cyc(); i_ls_req = 1'b0; i_ls_we = 1'b0; i_ls_bmask = 4'b0000;

    // fetch killed at cycle 1, ack at cycle 3, LSU pending from cycle 2
    cyc();
    i_if_req = 1'b1; i_if_addr = 32'h0000_0020; settle();
    check1("k_if_gnt_c0", o_if_gnt, 1'b1);
    cyc(); i_if_kill = 1'b1; settle();
    check1("k_memreq_c1", o_mem_req, 1'b1);
    check1("k_if_stall_c1", o_if_stall, 1'b0);
    cyc(); i_if_kill = 1'b0; i_if_req = 1'b0;
    i_ls_req = 1'b1; i_ls_addr = 32'h0000_0040; settle();
    check1("k_ls_gnt_c2", o_ls_gnt, 1'b0);
    check1("k_ls_stall_c2", o_ls_stall, 1'b1);
    cyc(); i_mem_ack = 1'b1; i_mem_rdata = 32'h1111_2222; settle();
    check1("k_ls_gnt_c3", o_ls_gnt, 1'b0);
    cyc(); i_mem_ack = 1'b0; settle();
    check1("k_if_rvalid_c4", o_if_rvalid, 1'b0);
    check32("k_if_rdata_c4", o_if_rdata, 32'h0000_0093);
    check1("k_ls_gnt_c4", o_ls_gnt, 1'b1);
    check1("k_memreq_c4", o_mem_req, 1'b0);
    cyc(); i_mem_ack = 1'b1; i_mem_rdata = 32'h3333_4444; settle();
    check32("k_ls_addr_c5", o_mem_addr, 32'h0000_0040);
    cyc(); i_mem_ack = 1'b0; settle();
    check1("k_ls_rvalid_c6", o_ls_rvalid, 1'b1);
    check32("k_ls_rdata_c6", o_ls_rdata, 32'h3333_4444);
    cyc(); i_ls_req = 1'b0;

    // reset during cycle 1 of a DATA transaction, stray ack at cycle 3
    cyc();
    i_ls_req = 1'b1; i_ls_addr = 32'h0000_0050; settle();
    check1("r_gnt_c0", o_ls_gnt, 1'b1);
    cyc(); i_rst_n = 1'b0; i_ls_req = 1'b0; settle();
    check1("r_memreq_c1", o_mem_req, 1'b1);
    cyc(); i_rst_n = 1'b1; settle();
    check1("r_memreq_c2", o_mem_req, 1'b0);
    check32("r_addr_c2", o_mem_addr, 32'd0);
    check32("r_ls_rdata_c2", o_ls_rdata, 32'd0);
    check32("r_if_rdata_c2", o_if_rdata, 32'd0);
    cyc(); i_mem_ack = 1'b1; i_mem_rdata = 32'h0000_0BAD; settle();
    check1("r_memreq_c3", o_mem_req, 1'b0);
    check1("r_ls_rvalid_c3", o_ls_rvalid, 1'b0);
    cyc(); i_mem_ack = 1'b0; settle();
    check1("r_ls_rvalid_c4", o_ls_rvalid, 1'b0);
    check32("r_ls_rdata_c4", o_ls_rdata, 32'd0);
    check1("r_memreq_c4", o_mem_req, 1'b0);
    cyc();

    // starvation guard, then randomized traffic, all against the model
    gq.delete();
    for (int c = 0; c < 30; c++) model_cycle(1);
    n_ls = 0; seen_f = 1'b0;
    foreach (gq[k]) begin
      if (!seen_f) begin
        if (gq[k] == 1) n_ls++;
        else seen_f = 1'b1;
      end
    end
    check32("starve_ls_grants", n_ls, 32'd4);
    check1("starve_fetch_won", seen_f, 1'b1);
    for (int c = 0; c < 800; c++) model_cycle(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported unified memory between the instruction-fetch stage and the load/store unit of the pipelined RV32I core. Exactly one transaction is outstanding at a time. LSU has fixed priority, with a starvation guard that periodically forces a fetch grant. The block produces per-requester stall signals, which the top level ORs into the fetch and memory stage stall controls, and a kill input that discards a fetch result after a branch redirect.

## Interface
Parameters
- STARVE_MAX, 4: consecutive LSU grants tolerated while fetch waits (range 1..15).

Ports
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_if_req  in  1  fetch request; held with i_if_addr stable until o_if_rvalid.
- i_if_addr  in  32  fetch byte address.
- i_if_kill  in  1  discard the in-flight or pending fetch (branch redirect).
- o_if_gnt  out  1  fetch request accepted this cycle.
- o_if_rvalid  out  1  one-cycle pulse; o_if_rdata valid.
- o_if_rdata  out  32  fetched instruction.
- o_if_stall  out  1  fetch must hold.
- i_ls_req  in  1  LSU request; held with payload stable until o_ls_rvalid.
- i_ls_we  in  1  1 = store, 0 = load.
- i_ls_addr  in  32  data byte address.
- i_ls_wdata  in  32  store data.
- i_ls_bmask  in  4  store byte enables.
- o_ls_gnt  out  1  LSU request accepted this cycle.
- o_ls_rvalid  out  1  one-cycle pulse; load data valid, or store complete.
- o_ls_rdata  out  32  load data; 0 for stores.
- o_ls_stall  out  1  LSU/M stage must hold.
- o_mem_req  out  1  memory request; held until i_mem_ack.
- o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask  out  1/32/32/4  registered payload.
- i_mem_ack  in  1  transaction complete; i_mem_rdata valid this cycle.
- i_mem_rdata  in  32  read data.

## Operation
- States:
  - IDLE: no transaction outstanding.
  - FETCH: fetch transaction outstanding.
  - DATA: LSU transaction outstanding.
- Eligibility in IDLE:
  - Fetch is eligible when i_if_req & ~i_if_kill & ~o_if_rvalid.
  - LSU is eligible when i_ls_req & ~o_ls_rvalid. A requester's own rvalid cycle therefore never re-grants the same request.
- Arbitration in IDLE:
  - Only one requester eligible: it wins.
  - Both eligible: LSU wins unless starve_cnt == STARVE_MAX, in which case fetch wins.
- Grant:
  - o_*_gnt is combinational, asserted in the decision cycle only.
  - At the grant edge, the payload is latched into the o_mem_* registers and the state moves to FETCH or DATA.
  - A fetch grant drives o_mem_we=0 and o_mem_bmask=4'b0000.
- starve_cnt, saturating, updated at each grant edge:
  - LSU granted while fetch eligible: +1.
  - Fetch granted, or LSU granted with fetch not eligible: reset to 0.
- o_mem_req is 1 in FETCH and DATA, 0 in IDLE. The payload is stable while o_mem_req=1.
- On i_mem_ack in FETCH or DATA:
  - State returns to IDLE.
  - The owner's rvalid is registered to 1 for the next cycle.
  - rdata is registered to i_mem_rdata, or to 0 for stores.
- i_mem_ack in IDLE is ignored.
- Kill:
  - If i_if_kill is seen in any cycle of FETCH, including the ack cycle, a sticky kill flag is set.
  - On ack with the flag set, o_if_rvalid stays 0 and o_if_rdata is unchanged. The flag clears on leaving FETCH.
- Stalls:
  - o_if_stall = i_if_req & ~o_if_rvalid & ~i_if_kill.
  - o_ls_stall = i_ls_req & ~o_ls_rvalid.
- Reset: every output, state, starve_cnt and the kill flag go to 0/IDLE at the first edge with i_rst_n=0.
  - Reset mid-transaction abandons the transaction: o_mem_req is 0 from the following cycle, and no rvalid is produced.
  - A later stray i_mem_ack is ignored under the IDLE rule.

## Timing
- Request to grant: 0 cycles, when IDLE and the requester wins.
- o_mem_req rises 1 cycle after grant.
- rvalid is 1 cycle after the i_mem_ack cycle.
- Minimum request-to-data is 2 cycles, when the ack arrives in the first o_mem_req cycle.
- A new grant is possible in the rvalid cycle, since the state is already IDLE. Back-to-back throughput is therefore one transaction per 2 cycles with a 1-cycle memory.
- Simultaneous ack and new requests: the requests are evaluated the next cycle, in IDLE.

## Test plan
- Lone fetch, addr 0x0000_0010, ack on the first o_mem_req cycle, rdata 0x0000_0013:
  - o_if_gnt at cycle 0.
  - o_mem_req at cycle 1.
  - o_if_rvalid=1 with rdata 0x13 at cycle 2.
  - o_if_stall=1 at cycles 0-1 and 0 at cycle 2.
- Load and fetch request together, 1-cycle memory:
  - LSU is granted first, fetch on the next IDLE.
  - o_ls_rdata equals i_mem_rdata; o_ls_stall drops in its rvalid cycle.
- Store, bmask 4'b0011, wdata 0xDEAD_BEEF:
  - o_mem_we=1 and the payload matches.
  - o_ls_rvalid pulses with o_ls_rdata=0.
- STARVE_MAX=4, LSU requesting continuously with fetch pending: exactly 4 LSU grants, then a fetch grant, then starve_cnt=0.
- Fetch in flight, i_if_kill pulsed at cycle 1, ack at cycle 3:
  - No o_if_rvalid.
  - An LSU request pending since cycle 2 is granted at cycle 4.
- i_rst_n=0 at cycle 1 of a DATA transaction, ack at cycle 3:
  - All outputs 0 from cycle 2 onward.
  - No o_ls_rvalid; state IDLE.
